serial_adder_ctrl: RTL and testbench

// - Bit-serial adder controller. Adds two WIDTH-bit operands through one 1-bit add cell
//   (two half-adder stages plus a registered carry), LSB first, one bit per clock.
// - Owns the operand shift registers, carry flop, bit counter and the start/busy/done handshake.
// - Sits between a requesting master and the adder cell. Trades WIDTH cycles of latency for
//   a single adder bit.
//

---
 rtl/serial_adder_ctrl_if.sv | 23 ++
 rtl/serial_adder_ctrl.sv | 109 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a master and the bit-serial adder controller.
// The master drives the operands and start. The controller returns the handshake and the result.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one 1-bit add cell walks LSB-first through WIDTH operand bits.
// sum/cout are held between results and change only when DONE is entered, or on reset.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  // Add cell: two half-adder stages feeding the registered carry.
  logic ha1_s, ha1_c, ha2_s, ha2_c, carry_nxt;

  assign ha1_s     = a_sh_q[0] ^ b_sh_q[0];
  assign ha1_c     = a_sh_q[0] & b_sh_q[0];
  assign ha2_s     = ha1_s ^ carry_q;
  assign ha2_c     = ha1_s & carry_q;
  assign carry_nxt = ha1_c | ha2_c;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = {ha2_s, res_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // The last bit lands in sum together with its carry, so the result appears on DONE entry.
          sum_d   = res_d;
          cout_d  = carry_nxt;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8: handshake timing, carry behaviour,
// ignored start, mid-run reset and back-to-back operation.
module tb_serial_adder_ctrl;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;

  serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_sum_held = '0;
  logic             exp_cout_held = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One add from IDLE. poke_at >= 0 drives a stray start with 1+1 at that RUN cycle.
  task automatic run_add(input string tag, input logic [WIDTH-1:0] op_a,
                         input logic [WIDTH-1:0] op_b, input logic [WIDTH-1:0] exp_sum,
                         input logic exp_cout, input int poke_at);
    bus.start = 1'b1;
    bus.a     = op_a;
    bus.b     = op_b;
    step();
    bus.a = ~op_a;
    bus.b = ~op_b;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == poke_at) begin
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
      end else begin
        bus.start = 1'b0;
      end
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_nodone"}, 32'(bus.done), 32'd0);
      check({tag, "_sum_held"}, 32'(bus.sum), 32'(exp_sum_held));
      step();
    end
    bus.start = 1'b0;
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
    check({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
    exp_sum_held  = exp_sum;
    exp_cout_held = exp_cout;
    step();
    check({tag, "_done_once"}, 32'(bus.done), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_sum_stable"}, 32'(bus.sum), 32'(exp_sum));
    check({tag, "_cout_stable"}, 32'(bus.cout), 32'(exp_cout));
  endtask

  initial begin
    int since_done;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_sum", 32'(bus.sum), 32'd0);
    check("reset_cout", 32'(bus.cout), 32'd0);
    step();
    check("idle_no_start", 32'(bus.busy), 32'd0);

    run_add("zero", 8'h00, 8'h00, 8'h00, 1'b0, -1);
    run_add("ripple", 8'hFF, 8'h01, 8'h00, 1'b1, -1);
    run_add("alt", 8'hA5, 8'h5A, 8'hFF, 1'b0, -1);
    run_add("msb", 8'h80, 8'h80, 8'h00, 1'b1, -1);
    run_add("poke", 8'h0F, 8'h01, 8'h10, 1'b0, 3);

    // Abort an add four cycles into RUN.
    bus.start = 1'b1;
    bus.a     = 8'h55;
    bus.b     = 8'h33;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_sum", 32'(bus.sum), 32'd0);
    check("abort_cout", 32'(bus.cout), 32'd0);
    exp_sum_held  = '0;
    exp_cout_held = 1'b0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      check("abort_no_done", 32'(bus.done), 32'd0);
      step();
    end
    run_add("after_abort", 8'h03, 8'h04, 8'h07, 1'b0, -1);

    // start held high: back-to-back adds, done pulses WIDTH+2 cycles apart.
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    step();
    bus.a = 8'hF0;
    for (int i = 0; i < WIDTH; i++) begin
      check("b2b1_busy", 32'(bus.busy), 32'd1);
      step();
    end
    check("b2b1_done", 32'(bus.done), 32'd1);
    check("b2b1_sum", 32'(bus.sum), 32'h30);
    check("b2b1_cout", 32'(bus.cout), 32'd0);
    since_done = 0;
    for (int i = 0; i < 4 * WIDTH; i++) begin
      step();
      since_done++;
      if (bus.done === 1'b1) break;
    end
    bus.start = 1'b0;
    check("b2b_spacing", 32'(since_done), 32'(WIDTH + 2));
    check("b2b2_done", 32'(bus.done), 32'd1);
    check("b2b2_busy", 32'(bus.busy), 32'd0);
    check("b2b2_sum", 32'(bus.sum), 32'h10);
    check("b2b2_cout", 32'(bus.cout), 32'd1);
    step();
    step();
    check("final_idle", 32'(bus.busy), 32'd0);
    check("final_sum", 32'(bus.sum), 32'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
